// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: turns a valid/ready request bus into single-port SRAM macro
// commands, tracks the fixed read latency and returns in-order responses
// through a small response FIFO guarded by a credit (outstanding) counter.
module sram_req_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RSP_DEPTH    = 2,
  localparam int unsigned NUM_WMASKS  = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_addr_i,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_WMASKS-1:0] req_wmask_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  csb_o,
  output logic                  web_o,
  output logic [NUM_WMASKS-1:0] wmask_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic [DATA_WIDTH-1:0] rdata_i
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned TAIL  = READ_LATENCY - 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  req_err;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] push_data;

  cnt_t                  outstanding;
  cnt_t                  fifo_cnt;
  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;

  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_read;
  logic [READ_LATENCY-1:0] pipe_err;

  logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
  logic                  fifo_err  [RSP_DEPTH];

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_err     = ((req_addr_i >> (ADDR_WIDTH + 2)) != '0) || (req_addr_i[1:0] != 2'b00);
  assign req_ready_o = !rst_i && (outstanding < cnt_t'(RSP_DEPTH));
  assign accept      = req_valid_i && req_ready_o;

  assign fifo_empty  = (fifo_cnt == '0);
  assign rsp_valid_o = !fifo_empty;
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign push        = pipe_valid[TAIL];
  assign push_data   = (pipe_read[TAIL] && !pipe_err[TAIL]) ? rdata_i : '0;

  // Head entry is gated by empty so the response bus reads zero when idle.
  assign rsp_rdata_o = fifo_empty ? '0 : fifo_data[rd_ptr];
  assign rsp_err_o   = fifo_empty ? 1'b0 : fifo_err[rd_ptr];

  // Drive the SRAM command only in the accept cycle of an error-free request.
  always_comb begin
    csb_o   = 1'b1;
    web_o   = 1'b1;
    wmask_o = '0;
    addr_o  = '0;
    wdata_o = '0;
    if (accept && !req_err) begin
      csb_o   = 1'b0;
      web_o   = !req_we_i;
      addr_o  = req_addr_i[ADDR_WIDTH+1:2];
      wdata_o = req_wdata_i;
      if (req_we_i) begin
        wmask_o = req_wmask_i;
      end
    end
  end

  // Credit counter: requests accepted but whose response is not yet popped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Latency pipeline: advances every cycle, tail lines up with rdata_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      pipe_read  <= '0;
      pipe_err   <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_read[0]  <= !req_we_i;
      pipe_err[0]   <= req_err;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_read[i]  <= pipe_read[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
    end
  end

  // Response FIFO pointers and occupancy; pop frees the head before push writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Response FIFO storage written at the pipeline tail.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_err[i]  <= 1'b0;
      end
    end else if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_err[wr_ptr]  <= pipe_err[TAIL];
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Scoreboard bench for sram_req_ctrl with an SRAM macro model and a
// word-level reference memory.
module tb_sram_req_ctrl;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 4;
  localparam int unsigned RL = 1;
  localparam int unsigned RD = 2;
  localparam int unsigned WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready_o;
  logic [31:0]   req_addr = '0;
  logic          req_we = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic [NW-1:0] req_wmask = '0;
  logic          rsp_valid_o;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          csb_o;
  logic          web_o;
  logic [NW-1:0] wmask_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [DW-1:0] sram_rdata = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_req_ctrl #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(RL),
    .RSP_DEPTH   (RD)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr),
    .req_we_i    (req_we),
    .req_wdata_i (req_wdata),
    .req_wmask_i (req_wmask),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .csb_o       (csb_o),
    .web_o       (web_o),
    .wmask_o     (wmask_o),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .rdata_i     (sram_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] seed_word(input int unsigned i);
    return (32'h9E3779B9 * i) ^ 32'h5A5AA5A5;
  endfunction

  // SRAM macro with one cycle of read latency.
  logic [31:0] sram [WORDS];
  always @(posedge clk) begin
    if (!csb_o) begin
      if (!web_o) begin
        for (int b = 0; b < NW; b++)
          if (wmask_o[b]) sram[addr_o][8*b +: 8] <= wdata_o[8*b +: 8];
      end else begin
        sram_rdata <= sram[addr_o];
      end
    end
  end

  // Reference model: byte-masked word memory updated in acceptance order.
  logic [31:0] ref_mem [WORDS];
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t exp_q[$];

  initial begin
    for (int unsigned i = 0; i < WORDS; i++) begin
      sram[i]    = seed_word(i);
      ref_mem[i] = seed_word(i);
    end
  end

  int unsigned m_out = 0;
  logic        held = 1'b0;
  logic [31:0] held_d = '0;
  logic        held_e = 1'b0;
  logic        acc, pop_now, e_err;
  rsp_t        e, got;

  // Monitor: checks command bus at acceptance, pops/compares responses.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      m_out = 0;
      held  = 1'b0;
      chk("rst_ready", req_ready_o, 0);
      chk("rst_csb", csb_o, 1);
      chk("rst_web", web_o, 1);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_rsp_rdata", rsp_rdata_o, 0);
      chk("rst_rsp_err", rsp_err_o, 0);
      chk("rst_sram_bus", {wmask_o, addr_o, wdata_o}, 0);
    end else begin
      pop_now = rsp_valid_o && rsp_ready;
      acc     = req_valid && req_ready_o;
      if (held) begin
        chk("hold_valid", rsp_valid_o, 1);
        chk("hold_rdata", rsp_rdata_o, held_d);
        chk("hold_err", rsp_err_o, held_e);
      end
      held   = rsp_valid_o && !rsp_ready;
      held_d = rsp_rdata_o;
      held_e = rsp_err_o;
      if (pop_now) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got rdata 0x%0h err %0d, none expected", rsp_rdata_o, rsp_err_o);
        end else begin
          got = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata_o, got.rdata);
          chk("rsp_err", rsp_err_o, got.err);
        end
      end
      chk("req_ready", req_ready_o, m_out < RD);
      if (acc) begin
        e_err = (req_addr >= (32'd4 * WORDS)) || ((req_addr % 4) != 0);
        e.err = e_err;
        e.rdata = '0;
        if (e_err) begin
          chk("err_csb", csb_o, 1);
        end else begin
          chk("iss_csb", csb_o, 0);
          chk("iss_web", web_o, !req_we);
          chk("iss_addr", addr_o, req_addr / 4);
          chk("iss_wdata", wdata_o, req_wdata);
          chk("iss_wmask", wmask_o, req_we ? req_wmask : 4'h0);
          if (req_we) begin
            for (int b = 0; b < NW; b++)
              if (req_wmask[b]) ref_mem[req_addr / 4][8*b +: 8] = req_wdata[8*b +: 8];
          end else begin
            e.rdata = ref_mem[req_addr / 4];
          end
        end
        exp_q.push_back(e);
      end else begin
        chk("idle_csb", csb_o, 1);
        chk("idle_web", web_o, 1);
      end
      m_out = m_out + (acc ? 1 : 0) - (pop_now ? 1 : 0);
    end
  end

  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    forever begin
      @(negedge clk);
      if (req_ready_o) break;
      n++;
      if (n > 100) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: addr 0x%0h not accepted in 100 cycles", a);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      if (exp_q.size() == 0 && !rsp_valid_o) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout: %0d responses still expected", exp_q.size());
        break;
      end
    end
    #1;
  endtask

  logic        rnd_done = 1'b0;
  logic [31:0] ra;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_ready = 1'b1;
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_i = 1'b0;

    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    send(1'b0, 32'h10, 32'h0, 4'h0);
    send(1'b1, 32'h14, 32'hAABBCCDD, 4'hF);
    send(1'b1, 32'h14, 32'h11223344, 4'h3);
    send(1'b0, 32'h14, 32'h0, 4'hF);
    send(1'b0, 32'h8000, 32'h0, 4'h0);
    send(1'b0, 32'h6, 32'h0, 4'h0);
    send(1'b0, 32'h7FFC, 32'h0, 4'h0);
    drain();

    for (int i = 0; i < 4; i++) send(1'b0, 32'(i * 4), 32'h0, 4'h0);
    drain();

    rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(1'b0, 32'h20 + 32'(i * 4), 32'h0, 4'h0);
      end
      begin
        repeat (8) @(posedge clk);
        #2 rsp_ready = 1'b1;
      end
    join
    drain();

    fork
      begin
        for (int k = 0; k < 250; k++) begin
          int unsigned r;
          int unsigned gap;
          gap = $urandom_range(0, 2);
          if (gap != 0) begin
            repeat (gap) @(posedge clk);
            #1;
          end
          r = $urandom_range(0, 11);
          case (r)
            0:       ra = 32'h8000 + ($urandom_range(0, 255) << 2);
            1:       ra = ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
            2:       ra = $urandom | 32'h8000_0000;
            3:       ra = 32'h7FFC;
            default: ra = $urandom_range(0, 15) << 2;
          endcase
          send(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #2 rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    rsp_ready = 1'b0;
    send(1'b0, 32'h10, 32'h0, 4'h0);
    send(1'b0, 32'h14, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    chk("pre_rst_valid", rsp_valid_o, 1);
    #3 rst_i = 1'b1;
    #1;
    chk("async_rst_valid", rsp_valid_o, 0);
    chk("async_rst_ready", req_ready_o, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_i = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid_o, 0);
    end
    send(1'b0, 32'h14, 32'h0, 4'h0);
    drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
